mul_seq_ctrl: RTL
=================

# mul_seq_ctrl

Sequencing controller for the multiply functional unit. It accepts one unsigned 32×32 multiply from the reservation station. It then drives a single 32-bit partial-product AND array, one multiplier bit per cycle, and accumulates a 64-bit product. It presents the tagged result to the common data bus (CDB) arbiter with a valid/ready handshake.

## Interface
Parameters:
- TAG_W, 4, width of the reservation-station tag carried with each operation

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of any in-flight or pending operation
- in_valid  input  1  reservation station offers an operation
- in_ready  output  1  controller accepts; equals (state==IDLE && !flush), combinational
- in_a  input  32  multiplicand
- in_b  input  32  multiplier
- in_tag  input  TAG_W  destination tag
- out_valid  output  1  result pending for CDB
- out_ready  input  1  CDB grant
- out_prod  output  64  unsigned product
- out_tag  output  TAG_W  tag of out_prod
- busy  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: out_valid=0, out_prod=0, out_tag=0, busy=0. in_ready=1 while flush=0.
- Internal registers:
  - A: 64-bit multiplicand, zero-extended.
  - B: 32-bit remaining multiplier.
  - acc: 64-bit accumulator.
  - cnt: 5-bit bit index.
  - tag: TAG_W-bit operation tag.
- IDLE: on in_valid && in_ready, load A={32'b0,in_a}, B=in_b, acc=0, cnt=0, tag=in_tag, then go to RUN.
- RUN, each cycle:
  - Partial product pp = in_a-field of A ANDed with {32{B[0]}}.
  - acc += {32'b0,pp} << cnt, using 64-bit modulo arithmetic. No overflow is possible for unsigned 32×32.
  - B >>= 1, cnt += 1.
  - After the step with cnt==31, go to DONE.
- DONE: out_valid=1. out_prod=acc and out_tag=tag, both held stable until the handshake completes. On out_ready, go to IDLE and deassert out_valid.
- flush has highest priority in every state. It forces the next state to IDLE and out_valid=0 on the next edge, and discards the accumulator. in_ready is 0 during flush, so an in_valid in the same cycle is not accepted.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- busy = (state != IDLE).

## Timing
- Accept at edge E. RUN occupies the cycles after edges E through E+31, and the state becomes DONE at edge E+32. out_valid is visible in the cycle after edge E+32, so latency is 32 cycles.
- Handshake completes at the edge where out_valid && out_ready. The state is IDLE after that edge, and in_ready rises in the following cycle.
- There is no accept in the same cycle as a DONE→IDLE transfer. Minimum initiation interval is 34 cycles.
- Asynchronous reset mid-operation returns to IDLE immediately with all outputs at their reset values. No partial result is emitted.
- Output registers change only on entry to DONE, on reset, or on flush.

## Configuration
- MUL_EARLY_TERM_EN defined: in RUN, if the shifted B (after this step) is zero, go to DONE at this edge. This also applies when cnt<31.
  - Latency = max(1, index of the highest set bit of in_b + 1) cycles.
  - in_b=0 gives out_valid one cycle after accept, with product 0.
- Not defined: RUN always lasts exactly 32 cycles regardless of operands.
- The result value is identical in both configurations.

## Test plan
- in_a=3, in_b=5, tag=2, out_ready=1 → out_prod=0x000000000000000F, out_tag=2. out_valid rises 32 cycles after accept (3 cycles with MUL_EARLY_TERM_EN).
- in_a=in_b=0xFFFFFFFF → out_prod=0xFFFFFFFE00000001 after 32 cycles in both configurations.
- Hold out_ready=0 for 10 cycles in DONE → out_valid, out_prod and out_tag stay stable. in_ready=0 and in_valid is ignored. Raising out_ready completes the handshake and in_ready=1 the next cycle.
- Assert flush in the 10th RUN cycle with in_valid=1 → IDLE next edge, no out_valid, no accept that cycle. A following op of 7×6 returns 42 with its own tag.
- in_b=1 → with macro, out_valid one cycle after accept, product=in_a. Without macro, out_valid after 32 cycles.
- Drive rst_n low mid-RUN → outputs go to 0 immediately and in_ready=1 after release. The next op of 0x10000×0x10000 returns 0x0000000100000000.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencing controller for the multiply functional unit.
// Takes one unsigned 32x32 multiply from the reservation station, and
// accumulates one partial product per cycle (shift-and-add, LSB first).
// The tagged 64-bit product goes to the CDB arbiter over valid/ready.
//
// Handshakes: a transfer happens on the rising edge where valid && ready
// are both high. in_ready is combinational (IDLE and no flush). out_valid
// is registered, and out_prod/out_tag stay stable while out_valid is high
// until out_ready is seen.
//
// Optional feature macro: MUL_EARLY_TERM_EN. When defined, RUN ends as soon
// as the remaining multiplier bits are all zero. The product is the same.
module mul_seq_ctrl #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_prod,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [63:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [63:0]      acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_prod_q, out_prod_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             step_last;
    logic [63:0]      pp;
    logic [63:0]      acc_sum;

    // Decide whether the current RUN step is the final one.
    always_comb begin
`ifdef MUL_EARLY_TERM_EN
        step_last = (b_q[31:1] == 31'd0);
`else
        step_last = (cnt_q == 5'd31);
`endif
    end

    // Partial product of the current multiplier bit, weighted by its index.
    always_comb begin
        pp      = a_q & {64{b_q[0]}};
        acc_sum = acc_q + (pp << cnt_q);
    end

    // State and datapath registers; async reset returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_prod_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            out_prod_q  <= out_prod_d;
            out_tag_q   <= out_tag_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid && in_ready) state_d = RUN;
            RUN:  if (step_last)            state_d = DONE;
            DONE: if (out_ready)            state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Datapath next values: load on accept, shift-and-add in RUN, and
    // capture the result into the output registers on entry to DONE.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        out_valid_d = out_valid_q;
        out_prod_d  = out_prod_q;
        out_tag_d   = out_tag_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d   = {32'b0, in_a};
                    b_d   = in_b;
                    acc_d = '0;
                    cnt_d = '0;
                    tag_d = in_tag;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (step_last) begin
                    out_valid_d = 1'b1;
                    out_prod_d  = acc_sum;
                    out_tag_d   = tag_q;
                end
            end
            DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
        // An aborted operation leaves nothing behind.
        if (flush) begin
            acc_d       = '0;
            out_valid_d = 1'b0;
            out_prod_d  = '0;
            out_tag_d   = '0;
        end
    end

    // Output decode.
    always_comb begin
        in_ready  = (state_q == IDLE) && !flush;
        busy      = (state_q != IDLE);
        out_valid = out_valid_q;
        out_prod  = out_prod_q;
        out_tag   = out_tag_q;
    end

endmodule
